// File: rtl/program_loader_if.sv
// Instruction field stream between host/boot logic and the program loader.
interface program_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_dst;
  logic [4:0]  in_src1;
  logic [4:0]  in_src2;
  logic [31:0] in_imm;

  // Host side: offers field sets
  modport master (
    output in_valid, in_fmt, in_opcode, in_dst, in_src1, in_src2, in_imm,
    input  in_ready
  );

  // Loader side: consumes field sets
  modport slave (
    input  in_valid, in_fmt, in_opcode, in_dst, in_src1, in_src2, in_imm,
    output in_ready
  );
endinterface

// File: rtl/program_loader.sv
// Encodes R/M/B/J instruction field sets into 32-bit words and writes them
// sequentially into instruction memory during a start..finish load session.
// Optional feature macro: LOADER_RANGE_CHECK_EN (immediate range checking;
// illegal sets are consumed without a write and raise a sticky err).
module program_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  program_loader_if.slave   bus,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              full,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [1:0]  FMT_M = 2'd1;
  localparam logic [1:0]  FMT_B = 2'd2;
  localparam logic [1:0]  FMT_J = 2'd3;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t           state_q, state_d;
  logic             accept_c;
  logic             legal_c;
  logic             write_c;
  logic             err_d;
  logic [CNT_W-1:0] count_d;
  logic [31:0]      enc_c;

  // Ready whenever a session is open and memory has room; count doubles as write pointer
  assign bus.in_ready = (state_q == LOAD) && !full;
  assign accept_c     = bus.in_valid && bus.in_ready;

  // Pack fields into the decode-stage word layout; B offsets are stored in words
  always_comb begin
    enc_c = {bus.in_opcode, bus.in_dst, bus.in_src1, bus.in_src2, 10'd0};
    case (bus.in_fmt)
      FMT_M: enc_c[14:0] = bus.in_imm[14:0];
      FMT_B: begin
        enc_c[24:20] = bus.in_imm[16:12];
        enc_c[9:0]   = bus.in_imm[11:2];
      end
      FMT_J: begin
        enc_c[24:20] = bus.in_imm[19:15];
        enc_c[14:0]  = bus.in_imm[14:0];
      end
      default: ;
    endcase
  end

`ifdef LOADER_RANGE_CHECK_EN
  // Immediate must fit the field without loss (sign-extension bits all equal)
  always_comb begin
    legal_c = 1'b1;
    case (bus.in_fmt)
      FMT_M: legal_c = (&bus.in_imm[31:14]) || (~|bus.in_imm[31:14]);
      FMT_B: legal_c = (bus.in_imm[1:0] == 2'b00) &&
                       ((&bus.in_imm[31:16]) || (~|bus.in_imm[31:16]));
      FMT_J: legal_c = ~|bus.in_imm[31:20];
      default: ;
    endcase
  end
`else
  // Without checking, immediates are truncated by the encoder
  logic unused_imm;
  assign legal_c    = 1'b1;
  assign unused_imm = ^bus.in_imm[31:20];
`endif

  // Session FSM plus counter/error next values; start overrides everything,
  // including a set offered in the same cycle
  always_comb begin
    state_d = state_q;
    count_d = count;
    err_d   = err;
    write_c = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (start) state_d = LOAD;
               else if (finish) state_d = DONE;
      DONE:    if (start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
    if (start) begin
      count_d = '0;
      err_d   = 1'b0;
    end else if (accept_c) begin
      if (legal_c) begin
        write_c = 1'b1;
        count_d = count + CNT_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Registered memory write port and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      count      <= '0;
      busy       <= 1'b0;
      full       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= write_c;
      if (write_c) begin
        imem_addr  <= count[ADDR_W-1:0];
        imem_wdata <= enc_c;
      end
      count <= count_d;
      full  <= (count_d == CNT_W'(DEPTH));
      busy  <= (state_d == LOAD);
      done  <= (state_d == DONE);
      err   <= err_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus a random
// stream, checked against a transaction-level model of the load session.
module tb_program_loader;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int MD_IDLE = 0;
  localparam int MD_LOAD = 1;
  localparam int MD_DONE = 2;
`ifdef LOADER_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              finish;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [CNT_W-1:0]  count;
  logic              busy, full, done, err;

  program_loader_if bus();

  program_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .finish     (finish),
    .bus        (bus),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .busy       (busy),
    .full       (full),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_mode;
  int m_count;
  bit m_err;
  int n_strobes;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference encoding built from field values with plain arithmetic
  function automatic logic [31:0] encode(int fmt, int op, int dst, int s1, int s2,
                                         logic [31:0] imm);
    longint si, wo, fd, low;
    si = longint'($signed(imm));
    wo = si >>> 2;
    case (fmt)
      0:       begin fd = dst; low = s2 * 1024; end
      1:       begin fd = dst; low = si & 'h7fff; end
      2:       begin fd = (wo >>> 10) & 31; low = s2 * 1024 + (wo & 'h3ff); end
      default: begin fd = (si >>> 15) & 31; low = si & 'h7fff; end
    endcase
    return 32'(longint'(op) * (1 << 25) + fd * (1 << 20) + longint'(s1) * (1 << 15) + low);
  endfunction

  function automatic bit legal(int fmt, logic [31:0] imm);
    longint si;
    si = longint'($signed(imm));
    if (!RANGE_EN) return 1'b1;
    case (fmt)
      1:       return (si >= -16384) && (si <= 16383);
      2:       return (imm[1:0] == 2'b00) && (si >= -65536) && (si <= 65532);
      3:       return imm <= 32'd1048575;
      default: return 1'b1;
    endcase
  endfunction

  // Drive one cycle of stimulus, advance the model, check every output
  task automatic step(bit st, bit fin, bit v, int fmt, int op, int dst, int s1, int s2,
                      logic [31:0] imm);
    bit          rdy, acc, we_e;
    int          addr_e;
    logic [31:0] data_e;
    start = st; finish = fin; bus.in_valid = v;
    bus.in_fmt = 2'(fmt); bus.in_opcode = 7'(op); bus.in_dst = 5'(dst);
    bus.in_src1 = 5'(s1); bus.in_src2 = 5'(s2); bus.in_imm = imm;
    #1;
    rdy = (m_mode == MD_LOAD) && (m_count != DEPTH);
    check("in_ready", 64'(bus.in_ready), 64'(rdy));
    acc = v && rdy; we_e = 1'b0; addr_e = 0; data_e = '0;
    if (st) begin
      m_mode = MD_LOAD; m_count = 0; m_err = 1'b0;
    end else begin
      if (acc) begin
        if (legal(fmt, imm)) begin
          we_e = 1'b1; addr_e = m_count;
          data_e = encode(fmt, op, dst, s1, s2, imm);
          m_count++;
        end else begin
          m_err = 1'b1;
        end
      end
      if (m_mode == MD_LOAD && fin) m_mode = MD_DONE;
    end
    @(posedge clk);
    @(negedge clk);
    check("imem_we", 64'(imem_we), 64'(we_e));
    if (imem_we) n_strobes++;
    if (we_e) begin
      check("imem_addr", 64'(imem_addr), 64'(addr_e));
      check("imem_wdata", 64'(imem_wdata), 64'(data_e));
    end
    check("count", 64'(count), 64'(m_count));
    check("full", 64'(full), 64'(m_count == DEPTH));
    check("busy", 64'(busy), 64'(m_mode == MD_LOAD));
    check("done", 64'(done), 64'(m_mode == MD_DONE));
    check("err", 64'(err), 64'(m_err));
    start = 1'b0; finish = 1'b0; bus.in_valid = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 32'd0);
  endtask

  // Assert reset asynchronously and confirm outputs clear without a clock edge
  task automatic reset_check(string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_we"},    64'(imem_we),      64'd0);
    check({tag, "_addr"},  64'(imem_addr),    64'd0);
    check({tag, "_wdata"}, 64'(imem_wdata),   64'd0);
    check({tag, "_count"}, 64'(count),        64'd0);
    check({tag, "_busy"},  64'(busy),         64'd0);
    check({tag, "_full"},  64'(full),         64'd0);
    check({tag, "_done"},  64'(done),         64'd0);
    check({tag, "_err"},   64'(err),          64'd0);
    check({tag, "_rdy"},   64'(bus.in_ready), 64'd0);
    m_mode = MD_IDLE; m_count = 0; m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; finish = 1'b0;
    bus.in_valid = 1'b0; bus.in_fmt = '0; bus.in_opcode = '0; bus.in_dst = '0;
    bus.in_src1 = '0; bus.in_src2 = '0; bus.in_imm = '0;
    m_mode = MD_IDLE; m_count = 0; m_err = 1'b0; n_strobes = 0;
    @(negedge clk);
    reset_check("rst");
    idle();

    // Encoding examples, one per format, addresses 0..3
    step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 0, 7'h00, 3, 1, 2, 32'd0);
    check("tp_r", 64'(imem_wdata), 64'h00308800);
    step(1'b0, 1'b0, 1'b1, 1, 7'h11, 4, 2, 0, 32'hFFFF_FFFC);
    check("tp_m", 64'(imem_wdata), 64'h22417FFC);
    step(1'b0, 1'b0, 1'b1, 2, 7'h00, 0, 1, 2, 32'hFFFF_FFF8);
    check("tp_b", 64'(imem_wdata), 64'h01F08BFE);
    step(1'b0, 1'b0, 1'b1, 3, 7'h00, 0, 0, 0, 32'h0001_2345);
    check("tp_j", 64'(imem_wdata), 64'h00202345);
    check("tp_j_addr", 64'(imem_addr), 64'd3);

    // Valid held for six sets against a four-word memory
    step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 32'd0);
    n_strobes = 0;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 0, i + 1, i, i, i, 32'd0);
    check("hold_strobes", 64'(n_strobes), 64'd4);
    check("hold_count", 64'(count), 64'(DEPTH));
    check("hold_ready", 64'(bus.in_ready), 64'd0);
    step(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 32'd0);
    check("hold_done", 64'(done), 64'd1);

`ifdef LOADER_RANGE_CHECK_EN
    // Out-of-range M immediate is consumed without a write
    step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 0, 1, 1, 1, 1, 32'd0);
    step(1'b0, 1'b0, 1'b1, 1, 2, 2, 2, 2, 32'd16384);
    check("rc_err", 64'(err), 64'd1);
    check("rc_we", 64'(imem_we), 64'd0);
    check("rc_count", 64'(count), 64'd1);
    step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 32'd0);
    check("rc_clr_err", 64'(err), 64'd0);
`endif

    // Accept in the finish cycle still writes, then the session closes
    step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 0, 7'h05, 6, 7, 8, 32'd0);
    check("fin_we", 64'(imem_we), 64'd1);
    check("fin_done", 64'(done), 64'd1);
    idle();

    // start together with finish in LOAD restarts the session
    step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 1, 7'h09, 1, 2, 3, 32'd100);
    step(1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0, 32'd0);
    check("sf_busy", 64'(busy), 64'd1);
    check("sf_count", 64'(count), 64'd0);

    // Reset asserted while a write strobe is in flight
    step(1'b0, 1'b0, 1'b1, 0, 1, 1, 1, 1, 32'd0);
    step(1'b0, 1'b0, 1'b1, 0, 2, 2, 2, 2, 32'd0);
    reset_check("midrst");
    idle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bit          st, fin, v;
      int          fmt;
      logic [31:0] imm;
      v   = ($urandom_range(0, 9) < 7);
      st  = !v && ($urandom_range(0, 5) == 0);
      fin = ($urandom_range(0, 15) == 0);
      fmt = int'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       imm = $urandom;
        1:       imm = 32'($urandom_range(0, 65535)) - 32'd32768;
        2:       imm = (32'($urandom_range(0, 262143)) - 32'd131072) & 32'hFFFF_FFFC;
        default: imm = 32'($urandom_range(0, 1200000));
      endcase
      step(st, fin, v, fmt, int'($urandom_range(0, 127)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), imm);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Instruction encoder and loader for the custom 32-bit instruction set: accepts instruction fields over a valid/ready stream, packs them into the instruction word format the core's decode stage expects, and writes the words sequentially into instruction memory. Sits between the host/boot interface and the instruction memory write port; the only producer of encoded instruction words in the design.

## Interface
- `ADDR_W`, 8: instruction memory word-address width.
- `DEPTH`, 256: number of loadable words, ≤ 2^ADDR_W.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  pulse; begins a load session at word address 0.
- `finish`  in  1  pulse; ends the load session.
- `in_valid`  in  1  input field set valid.
- `in_ready`  out  1  loader can accept a field set.
- `in_fmt`  in  2  0=R, 1=M, 2=B, 3=J.
- `in_opcode`  in  7  operation code.
- `in_dst`, `in_src1`, `in_src2`  in  5 each  register indices.
- `in_imm`  in  32  signed immediate: M offset, B byte offset, or J offset (unsigned).
- `imem_we`  out  1  instruction memory write strobe.
- `imem_addr`  out  ADDR_W  word address.
- `imem_wdata`  out  32  encoded instruction.
- `count`  out  ADDR_W+1  words written this session.
- `busy`, `full`, `done`, `err`  out  1 each  status.

## Operation
- Common fields: `[31:25]`=opcode, `[24:20]`=dst, `[19:15]`=src1, `[14:10]`=src2; all other bits 0 unless listed.
- R: common fields; `in_imm` ignored.
- M: `[14:0]`=`in_imm[14:0]` (overrides src2 field).
- B: word offset w=`in_imm>>>2`; `[24:20]`=w[14:10] (overrides dst), `[9:0]`=w[9:0]; src2 kept in `[14:10]`.
- J: `[24:20]`=`in_imm[19:15]`, `[14:0]`=`in_imm[14:0]`; src1 kept.
- FSM IDLE→LOAD on `start`; LOAD→DONE on `finish`; DONE→LOAD on `start`. `start` in LOAD restarts (count=0). `start` and `finish` together: `start` wins.
- `start` clears `count`, write pointer, `err`.
- `in_ready` = (state==LOAD) && !full. Accept = `in_valid && in_ready`.
- `full` = (`count`==DEPTH). `busy` = LOAD; `done` = DONE.
- Accepted legal word: `imem_addr`←pointer, `imem_wdata`←encoding, `imem_we`←1, pointer and `count` +1.
- Accept in same cycle as `finish`: word is written, then DONE.

## Timing
- Reset: state IDLE; `imem_we`, `imem_addr`, `imem_wdata`, `count`, `busy`, `full`, `done`, `err`, `in_ready` all 0.
- All outputs registered except `in_ready` (combinational from state/`full`).
- Latency: accept on edge N → `imem_we`=1 with addr/data and updated `count` during cycle N+1; `imem_we` is a single-cycle strobe per word.
- Throughput: one word per cycle until full.
- `busy`/`done` change the cycle after the `start`/`finish` edge; `in_ready` follows state.
- `full`: after the DEPTH-th write, `in_ready`=0 in the same cycle `count` reaches DEPTH; further `in_valid` held off, no wrap.
- Reset mid-session: immediate return to reset values; any in-flight strobe aborted.

## Configuration
- `LOADER_RANGE_CHECK_EN` defined: illegal immediates detected — M outside [-16384,16383]; B not multiple of 4 or outside [-65536,65532]; J outside [0,1048575]. Illegal set is accepted (consumed), not written, `count` unchanged, `err` set sticky until `start`.
- Undefined: no checks; immediates silently truncated per encoding; `err` tied 0.

## Test plan
- Reset, `start`, R op=0x00 dst=3 src1=1 src2=2 → cycle after accept `imem_we`=1, addr 0, wdata 0x00308800, `count`=1.
- M op=0x11 dst=4 src1=2 imm=-4 → wdata 0x22417FFC; B op=0 src1=1 src2=2 imm=-8 → 0x01F08BFE; J op=0 imm=0x12345 → 0x00202345; addresses 1,2,3.
- DEPTH=4, `in_valid` held for 6 sets → exactly 4 strobes addr 0–3, `full`=1, `in_ready`=0, `count`=4; `finish` → `done`=1.
- With `LOADER_RANGE_CHECK_EN`: M imm=16384 → consumed, no strobe, `err`=1, `count` unchanged; next `start` → `err`=0, `count`=0.
- Accept coinciding with `finish` → word written, then `done`=1, `in_ready`=0; `start` and `finish` together in LOAD → stays LOAD, `count`=0.
- `rst_n` low mid-stream after 2 writes → all outputs 0 immediately, state IDLE, `in_ready`=0.
